// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM encodings, default
// geometry and the slot-offset helper used to address packed frames.
package tdm_pkg;
  localparam int DEF_NCH   = 4;
  localparam int DEF_WIDTH = 1;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;
endpackage

// Bit offset of slot k inside a packed frame of w-bit slots.
`ifndef TDM_SLOT_OFS
`define TDM_SLOT_OFS(k, w) ((k) * (w))
`endif

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM demux: reset to 0, load to 1 on a sync beat,
// increment on an accepted data beat with natural power-of-two wrap.
// last flags the final slot of the frame.
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt,
  output logic             last
);

  // Slot index register; load wins over inc since a sync beat always restarts at slot 1.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= SEL_W'(1);
    else if (inc)  cnt <= cnt + SEL_W'(1);
  end

  assign last = (cnt == SEL_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// TDM demultiplexer: rebuilds an NCH-slot parallel word from a stream of
// single slots. HUNT drops beats until a sync beat; LOCK fills shadow
// registers and loads dout atomically on the beat that writes slot NCH-1.
// Optional build macro TDM_DEMUX_SYNC_CHECK_EN enables the sticky sync_err
// flag for syncs off slot 0 and missing syncs at slot 0.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   din_sync,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic                   dout_valid,
  output logic [SEL_W-1:0]       slot,
  output logic                   locked,
  output logic                   sync_err
);

  state_t                     state_q, state_d;
  logic                       acc, cnt_load, cnt_inc, complete, last;
  logic [SEL_W-1:0]           wr_idx;
  // Only slots 0..NCH-2 need storage; slot NCH-1 goes straight from din to dout.
  logic [(NCH-1)*WIDTH-1:0]   shadow;

  tdm_slot_cnt #(.NCH(NCH), .SEL_W(SEL_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (slot),
    .last (last)
  );

  assign locked = (state_q == ST_LOCK);
  // A sync beat always lands in slot 0, whatever the counter says.
  assign wr_idx = din_sync ? '0 : slot;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HUNT;
    else     state_q <= state_d;
  end

  // Next state and beat decode: which beats are accepted, counter control, frame completion.
  always_comb begin
    state_d  = state_q;
    acc      = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    complete = 1'b0;
    if (din_valid) begin
      if (din_sync) begin
        acc      = 1'b1;
        cnt_load = 1'b1;
        state_d  = ST_LOCK;
      end else if (state_q == ST_LOCK) begin
        acc      = 1'b1;
        cnt_inc  = 1'b1;
        complete = last;
      end
    end
  end

  // Partial-frame storage; stale data after a realign is always overwritten before the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (acc) begin
      for (int k = 0; k < NCH - 1; k++)
        if (wr_idx == SEL_W'(k)) shadow[`TDM_SLOT_OFS(k, WIDTH) +: WIDTH] <= din;
    end
  end

  // Output frame register: loaded whole on completion, with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= complete;
      if (complete) dout <= {din, shadow};
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic err_set;

  // Misalignment detect: sync while mid-frame, or a data beat where slot 0 was expected.
  always_comb begin
    err_set = 1'b0;
    if (din_valid && state_q == ST_LOCK)
      err_set = din_sync ? (slot != '0) : (slot == '0);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          sync_err <= 1'b0;
    else if (err_set) sync_err <= 1'b1;
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (WIDTH=1, NCH=4): table of directed vectors with
// explicit expectations, followed by random beats checked against a
// behavioural frame model.
module tb_tdm_demux4;
  localparam int NCH   = 4;
  localparam int WIDTH = 1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, din, din_valid, din_sync;
  logic [3:0] dout;
  logic       dout_valid;
  logic [1:0] slot;
  logic       locked, sync_err;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a frame buffer indexed by slot number.
  bit         m_lk, m_dv, m_err;
  int         m_slot;
  bit         m_sh[NCH];
  logic [3:0] m_dout;

  task automatic model_edge(input bit r, input bit d, input bit v, input bit s);
    if (r) begin
      m_lk = 0; m_dv = 0; m_err = 0; m_slot = 0; m_dout = '0;
      foreach (m_sh[k]) m_sh[k] = 0;
      return;
    end
    m_dv = 0;
    if (!v) return;
    if (s) begin
      if (m_lk && m_slot != 0 && ERR_EN) m_err = 1;
      m_sh[0] = d; m_slot = 1; m_lk = 1;
    end else if (m_lk) begin
      if (m_slot == 0 && ERR_EN) m_err = 1;
      m_sh[m_slot] = d;
      if (m_slot == NCH - 1) begin
        m_dout = '0;
        for (int k = 0; k < NCH; k++) m_dout = m_dout | (4'(m_sh[k]) << k);
        m_dv = 1;
      end
      m_slot = (m_slot + 1) % NCH;
    end
  endtask

  task automatic check(input string name, input logic [3:0] ed, input bit edv,
                       input logic [1:0] es, input bit elk, input bit eerr);
    vectors++;
    if (dout !== ed || dout_valid !== edv || slot !== es || locked !== elk || sync_err !== eerr) begin
      miscompares++;
      $display("FAIL %s: got dout=%b dv=%b slot=%0d locked=%b err=%b, want dout=%b dv=%b slot=%0d locked=%b err=%b",
               name, dout, dout_valid, slot, locked, sync_err, ed, edv, es, elk, eerr);
    end
  endtask

  // One clock: drive, let the edge happen, then compare against the model mid-cycle.
  task automatic cyc(input string name, input bit r, input bit d, input bit v, input bit s);
    rst = r; din = d; din_valid = v; din_sync = s;
    @(posedge clk);
    model_edge(r, d, v, s);
    @(negedge clk);
    check({name, "/model"}, m_dout, m_dv, 2'(m_slot), m_lk, m_err);
  endtask

  typedef struct {
    string      name;
    bit         r, d, v, s;
    logic [3:0] dout;
    bit         dv;
    logic [1:0] slot;
    bit         lk, err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string n, input bit r, input bit d, input bit v, input bit s,
                              input logic [3:0] ed, input bit edv, input logic [1:0] es,
                              input bit elk, input bit eerr);
    vec_t t;
    t.name = n; t.r = r; t.d = d; t.v = v; t.s = s;
    t.dout = ed; t.dv = edv; t.slot = es; t.lk = elk; t.err = eerr;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [3:0] pats[3];
    logic [3:0] p, prev;

    // Reset, then basic frame 1,0,0,1
    add("reset", 1,0,0,0, 4'b0000,0,0,0,0);
    add("reset", 1,0,0,0, 4'b0000,0,0,0,0);
    add("basic", 0,1,1,1, 4'b0000,0,1,1,0);
    add("basic", 0,0,1,0, 4'b0000,0,2,1,0);
    add("basic", 0,0,1,0, 4'b0000,0,3,1,0);
    add("basic", 0,1,1,0, 4'b1001,1,0,1,0);
    add("basic", 0,0,0,0, 4'b1001,0,0,1,0);

    // One-hot frames, slot k set
    prev = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        add("onehot", 0, (j == k), 1, (j == 0), (j == 3) ? (4'b0001 << k) : prev,
            (j == 3), 2'((j + 1) % 4), 1, 0);
      end
      prev = 4'b0001 << k;
    end

    // Hunt: unsynced beats are dropped
    add("hunt", 1,0,0,0, 4'b0000,0,0,0,0);
    add("hunt", 0,1,1,0, 4'b0000,0,0,0,0);
    add("hunt", 0,1,1,0, 4'b0000,0,0,0,0);
    add("hunt", 0,1,1,0, 4'b0000,0,0,0,0);
    add("hunt", 0,0,1,1, 4'b0000,0,1,1,0);
    add("hunt", 0,1,1,0, 4'b0000,0,2,1,0);
    add("hunt", 0,1,1,0, 4'b0000,0,3,1,0);
    add("hunt", 0,0,1,0, 4'b0110,1,0,1,0);

    // Realign mid-frame
    add("realign", 0,1,1,1, 4'b0110,0,1,1,0);
    add("realign", 0,1,1,0, 4'b0110,0,2,1,0);
    add("realign", 0,0,1,1, 4'b0110,0,1,1,1);
    add("realign", 0,1,1,0, 4'b0110,0,2,1,1);
    add("realign", 0,0,1,0, 4'b0110,0,3,1,1);
    add("realign", 0,1,1,0, 4'b1010,1,0,1,1);
    add("realign", 0,0,0,0, 4'b1010,0,0,1,1);

    // Reset overrides a sync beat on the same edge
    add("rst_beat", 1,1,1,1, 4'b0000,0,0,0,0);

    // Gapped frame 1,0,1,1 with 3 idle cycles between beats
    add("gaps", 0,1,1,1, 4'b0000,0,1,1,0);
    for (int i = 0; i < 3; i++) add("gaps", 0,0,0,0, 4'b0000,0,1,1,0);
    add("gaps", 0,0,1,0, 4'b0000,0,2,1,0);
    for (int i = 0; i < 3; i++) add("gaps", 0,1,0,1, 4'b0000,0,2,1,0);
    add("gaps", 0,1,1,0, 4'b0000,0,3,1,0);
    for (int i = 0; i < 3; i++) add("gaps", 0,0,0,0, 4'b0000,0,3,1,0);
    add("gaps", 0,1,1,0, 4'b1101,1,0,1,0);
    for (int i = 0; i < 3; i++) add("gaps", 0,0,0,0, 4'b1101,0,0,1,0);

    // Reset mid-frame, then a fresh frame 0,0,1,1
    add("midrst", 0,0,1,1, 4'b1101,0,1,1,0);
    add("midrst", 0,1,1,0, 4'b1101,0,2,1,0);
    add("midrst", 1,0,0,0, 4'b0000,0,0,0,0);
    add("midrst", 0,0,1,1, 4'b0000,0,1,1,0);
    add("midrst", 0,0,1,0, 4'b0000,0,2,1,0);
    add("midrst", 0,1,1,0, 4'b0000,0,3,1,0);
    add("midrst", 0,1,1,0, 4'b1100,1,0,1,0);

    // Full-rate back-to-back frames
    pats[0] = 4'b1001; pats[1] = 4'b0110; pats[2] = 4'b1111;
    prev = 4'b1100;
    for (int f = 0; f < 3; f++) begin
      p = pats[f];
      for (int j = 0; j < 4; j++)
        add("thruput", 0, p[j], 1, (j == 0), (j == 3) ? p : prev, (j == 3), 2'((j + 1) % 4), 1, 0);
      prev = p;
    end
    add("thruput", 0,0,0,0, 4'b1111,0,0,1,0);

    rst = 1'b1; din = 1'b0; din_valid = 1'b0; din_sync = 1'b0;
    m_lk = 0; m_dv = 0; m_err = 0; m_slot = 0; m_dout = '0;

    foreach (tbl[i]) begin
      cyc(tbl[i].name, tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].s);
      check(tbl[i].name, tbl[i].dout, tbl[i].dv, tbl[i].slot, tbl[i].lk, tbl[i].err & ERR_EN);
    end

    // Random beats against the model
    for (int i = 0; i < 1500; i++) begin
      cyc("rand", ($urandom_range(0, 99) < 2), 1'($urandom), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
